// File: rtl/dmem_arbiter_if.sv
// Bundle of the pipeline, debug and memory-side signals around the data-memory arbiter.
// The slave modport is the arbiter's view; master is the view of requesters plus memory.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          pipe_req;
    logic          pipe_we;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] pipe_wdata;
    logic [DW-1:0] pipe_rdata;
    logic          pipe_done;
    logic          pipe_stall;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_done;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
        output pipe_rdata, pipe_done, pipe_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output pipe_req, pipe_we, pipe_addr, pipe_wdata,
        input  pipe_rdata, pipe_done, pipe_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one fixed-latency data-memory port between the pipeline MEM stage and the debug port.
// Pipe has priority; a starve counter hands every (STARVE_MAX+1)-th contended grant to debug.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);
    localparam int CW = 4;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_PIPE, OWN_DBG} owner_t;

    state_t         r_state;
    state_t         w_state_nxt;
    owner_t         r_owner;
    logic [CW-1:0]  r_cnt;
    logic [SW-1:0]  r_starve_cnt;
    logic           r_mem_en;
    logic           r_mem_we;
    logic [AW-1:0]  r_mem_addr;
    logic [DW-1:0]  r_mem_wdata;
    logic [DW-1:0]  r_pipe_rdata;
    logic [DW-1:0]  r_dbg_rdata;
    logic           r_pipe_done;
    logic           r_dbg_done;
    logic           w_grant_pipe;
    logic           w_grant_dbg;
    logic           w_finish;
    logic           w_dbg_starved;

    assign w_dbg_starved = bus.dbg_req && (r_starve_cnt == SW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal driven here gets its default first so no path leaves one unassigned (no latch).
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_pipe = 1'b0;
        w_grant_dbg  = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_dbg_starved) begin
                    w_grant_dbg = 1'b1;
                end else if (bus.pipe_req) begin
                    w_grant_pipe = 1'b1;
                end else if (bus.dbg_req) begin
                    w_grant_dbg = 1'b1;
                end
                if (w_grant_pipe || w_grant_dbg) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWN_NONE;
            r_cnt        <= '0;
            r_starve_cnt <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_pipe_rdata <= '0;
            r_dbg_rdata  <= '0;
            r_pipe_done  <= 1'b0;
            r_dbg_done   <= 1'b0;
        end else begin
            r_pipe_done <= w_finish && (r_owner == OWN_PIPE);
            r_dbg_done  <= w_finish && (r_owner == OWN_DBG);

            if (w_grant_pipe) begin
                r_owner     <= OWN_PIPE;
                r_mem_en    <= 1'b1;
                r_mem_we    <= bus.pipe_we;
                r_mem_addr  <= bus.pipe_addr;
                r_mem_wdata <= bus.pipe_wdata;
                r_cnt       <= CW'(LAT - 1);
                if (!bus.dbg_req) begin
                    r_starve_cnt <= '0;
                end else if (r_starve_cnt != SW'(STARVE_MAX)) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else if (w_grant_dbg) begin
                r_owner      <= OWN_DBG;
                r_mem_en     <= 1'b1;
                r_mem_we     <= bus.dbg_we;
                r_mem_addr   <= bus.dbg_addr;
                r_mem_wdata  <= bus.dbg_wdata;
                r_cnt        <= CW'(LAT - 1);
                r_starve_cnt <= '0;
            end

            if (r_state == S_ACCESS && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            // Writes leave the owner's rdata register untouched.
            if (w_finish) begin
                r_mem_en <= 1'b0;
                if (!r_mem_we && r_owner == OWN_PIPE) begin
                    r_pipe_rdata <= bus.mem_rdata;
                end
                if (!r_mem_we && r_owner == OWN_DBG) begin
                    r_dbg_rdata <= bus.mem_rdata;
                end
            end

            if (r_state == S_DONE) begin
                r_owner <= OWN_NONE;
            end
        end
    end

    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.pipe_rdata = r_pipe_rdata;
    assign bus.pipe_done  = r_pipe_done;
    assign bus.dbg_rdata  = r_dbg_rdata;
    assign bus.dbg_done   = r_dbg_done;
    assign bus.pipe_stall = bus.pipe_req & ~r_pipe_done;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: requester tasks queue expected rdata, a negedge
// monitor pops on each done pulse and logs every memory access it sees.
module tb_dmem_arbiter;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int LAT        = 2;
    localparam int STARVE_MAX = 3;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } grant_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pipe[$];
    logic [31:0] exp_dbg[$];
    grant_t      grant_log[$];
    int          pipe_done_cnt = 0;
    int          dbg_done_cnt  = 0;
    int          run = 0;
    grant_t      cur;
    bit          abort_ok = 1'b0;
    bit          chk_no_stall = 1'b0;
    logic [31:0] mem_store [logic [31:0]];
    int          en_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    // Memory model: data appears only in the LAT-th enable cycle, junk otherwise.
    always @(posedge clk) begin
        if (!rst && bus.mem_en && bus.mem_we && en_cnt == LAT - 1)
            mem_store[bus.mem_addr] = bus.mem_wdata;
        en_cnt = (!rst && bus.mem_en) ? en_cnt + 1 : 0;
    end

    always @(negedge clk)
        bus.mem_rdata = (bus.mem_en && en_cnt == LAT - 1) ? mem_read(bus.mem_addr) : 32'hBAD0_BAD0;

    // Monitor: done pulses against the scoreboard, access length and field stability.
    always @(negedge clk) begin
        if (bus.pipe_done) begin
            pipe_done_cnt++;
            if (exp_pipe.size() == 0) check("pipe_done_spurious", 32'(bus.pipe_done), 32'd0);
            else check("pipe_rdata", bus.pipe_rdata, exp_pipe.pop_front());
        end
        if (bus.dbg_done) begin
            dbg_done_cnt++;
            if (exp_dbg.size() == 0) check("dbg_done_spurious", 32'(bus.dbg_done), 32'd0);
            else check("dbg_rdata", bus.dbg_rdata, exp_dbg.pop_front());
        end
        if (bus.mem_en) begin
            if (run == 0) begin
                cur = '{addr: bus.mem_addr, we: bus.mem_we, wdata: bus.mem_wdata};
                grant_log.push_back(cur);
            end else begin
                check("mem_addr_hold", bus.mem_addr, cur.addr);
                check("mem_we_hold", 32'(bus.mem_we), 32'(cur.we));
                check("mem_wdata_hold", bus.mem_wdata, cur.wdata);
            end
            run++;
        end else if (run > 0) begin
            if (!abort_ok) check("mem_en_cycles", 32'(run), 32'(LAT));
            run = 0;
        end
    end

    task automatic pipe_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata);
        bit seen = 1'b0;
        exp_pipe.push_back(exp_rdata);
        bus.pipe_req   = 1'b1;
        bus.pipe_we    = we;
        bus.pipe_addr  = addr;
        bus.pipe_wdata = wdata;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (bus.pipe_done) begin
                seen = 1'b1;
                check("pipe_stall_done", 32'(bus.pipe_stall), 32'd0);
            end else begin
                check("pipe_stall_pending", 32'(bus.pipe_stall), 32'd1);
            end
        end
        if (!seen) check("pipe_done_timeout", 32'(bus.pipe_done), 32'd1);
        @(posedge clk); #1;
        bus.pipe_req = 1'b0;
    endtask

    task automatic dbg_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata);
        bit seen = 1'b0;
        exp_dbg.push_back(exp_rdata);
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = we;
        bus.dbg_addr  = addr;
        bus.dbg_wdata = wdata;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (bus.dbg_done) seen = 1'b1;
            if (chk_no_stall) check("pipe_stall_dbg_only", 32'(bus.pipe_stall), 32'd0);
        end
        if (!seen) check("dbg_done_timeout", 32'(bus.dbg_done), 32'd1);
        @(posedge clk); #1;
        bus.dbg_req = 1'b0;
    endtask

    task automatic wait_mem_en(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus.mem_en) seen = 1'b1;
        end
        if (!seen) check(name, 32'(bus.mem_en), 32'd1);
    endtask

    logic [31:0] exp_order [6] = '{32'h100, 32'h104, 32'h108, 32'h200, 32'h10C, 32'h110};
    int pd, dd;

    initial begin
        rst = 1'b1;
        bus.pipe_req = 1'b0; bus.pipe_we = 1'b0; bus.pipe_addr = '0; bus.pipe_wdata = '0;
        bus.dbg_req  = 1'b0; bus.dbg_we  = 1'b0; bus.dbg_addr  = '0; bus.dbg_wdata  = '0;
        mem_store[32'h10] = 32'hDEADBEEF;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_pipe_done", 32'(bus.pipe_done), 32'd0);
        check("rst_dbg_done", 32'(bus.dbg_done), 32'd0);
        check("rst_pipe_rdata", bus.pipe_rdata, 32'd0);
        check("rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Pipe load from 0x10.
        grant_log.delete();
        pipe_access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        check("t1_grants", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() > 0) begin
            check("t1_addr", grant_log[0].addr, 32'h10);
            check("t1_we", 32'(grant_log[0].we), 32'd0);
        end

        // Debug write to 0x20; dbg_rdata keeps its reset value.
        grant_log.delete();
        chk_no_stall = 1'b1;
        dbg_access(1'b1, 32'h20, 32'h12345678, 32'h0);
        chk_no_stall = 1'b0;
        check("t2_grants", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() > 0) begin
            check("t2_addr", grant_log[0].addr, 32'h20);
            check("t2_we", 32'(grant_log[0].we), 32'd1);
            check("t2_wdata", grant_log[0].wdata, 32'h12345678);
        end

        // Simultaneous requests: pipe first, then dbg.
        grant_log.delete();
        pd = pipe_done_cnt; dd = dbg_done_cnt;
        fork
            pipe_access(1'b0, 32'h20, 32'h0, 32'h12345678);
            dbg_access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        join
        check("t3_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("t3_first", grant_log[0].addr, 32'h20);
            check("t3_second", grant_log[1].addr, 32'h10);
        end
        check("t3_pipe_dones", 32'(pipe_done_cnt - pd), 32'd1);
        check("t3_dbg_dones", 32'(dbg_done_cnt - dd), 32'd1);

        // Starvation: pipe held continuously while dbg waits.
        grant_log.delete();
        fork
            begin
                pipe_access(1'b0, 32'h100, 32'h0, 32'hC0DE0100);
                pipe_access(1'b0, 32'h104, 32'h0, 32'hC0DE0104);
                pipe_access(1'b0, 32'h108, 32'h0, 32'hC0DE0108);
                pipe_access(1'b0, 32'h10C, 32'h0, 32'hC0DE010C);
                pipe_access(1'b0, 32'h110, 32'h0, 32'hC0DE0110);
            end
            dbg_access(1'b0, 32'h200, 32'h0, 32'hC0DE0200);
            begin
                for (int n = 0; n < 100 && grant_log.size() < 4; n++) @(negedge clk);
                check("t4_starve_cleared", 32'(dut.r_starve_cnt), 32'd0);
            end
        join
        check("t4_grants", 32'(grant_log.size()), 32'd6);
        if (grant_log.size() == 6) begin
            for (int i = 0; i < 6; i++) check("t4_order", grant_log[i].addr, exp_order[i]);
        end

        // Reset during the second ACCESS cycle aborts with no done pulse.
        grant_log.delete();
        pd = pipe_done_cnt; dd = dbg_done_cnt;
        bus.pipe_req = 1'b1; bus.pipe_we = 1'b0; bus.pipe_addr = 32'h30;
        bus.dbg_req  = 1'b1; bus.dbg_we  = 1'b0; bus.dbg_addr  = 32'h40;
        wait_mem_en("t5_grant_timeout");
        @(posedge clk); #1;
        rst = 1'b1; abort_ok = 1'b1;
        bus.pipe_req = 1'b0; bus.dbg_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_mem_en", 32'(bus.mem_en), 32'd0);
        check("t5_starve", 32'(dut.r_starve_cnt), 32'd0);
        repeat (5) @(negedge clk);
        abort_ok = 1'b0;
        check("t5_no_pipe_done", 32'(pipe_done_cnt - pd), 32'd0);
        check("t5_no_dbg_done", 32'(dbg_done_cnt - dd), 32'd0);
        check("t5_grants", 32'(grant_log.size()), 32'd1);
        @(posedge clk); #1;
        pipe_access(1'b0, 32'h30, 32'h0, 32'hC0DE0030);

        // Pipe drops req right after its grant.
        grant_log.delete();
        pd = pipe_done_cnt;
        exp_pipe.push_back(32'hC0DE0044);
        bus.pipe_req = 1'b1; bus.pipe_we = 1'b0; bus.pipe_addr = 32'h44;
        wait_mem_en("t6_grant_timeout");
        @(posedge clk); #1;
        bus.pipe_req = 1'b0;
        repeat (8) @(negedge clk);
        check("t6_pipe_dones", 32'(pipe_done_cnt - pd), 32'd1);
        check("t6_grants", 32'(grant_log.size()), 32'd1);

        check("exp_pipe_drained", 32'(exp_pipe.size()), 32'd0);
        check("exp_dbg_drained", 32'(exp_dbg.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
